// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: queues scan-code bytes and serialises each one as an
// 11-bit frame (start, 8 data LSB first, odd parity, stop), driving ps2_clk and ps2_data.
module ps2_device_tx #(
  parameter int unsigned CLK_DIV    = 50,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GAP_CYCLES = 100
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned TMR_MAX  = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
  localparam int unsigned LAST_BIT = 10;

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  state_t             state, state_d;
  logic [TMR_W-1:0]   tmr, tmr_d;
  logic [3:0]         bit_idx, bit_idx_d;
  logic [10:0]        frame, frame_d;
  logic               ps2_clk_d, ps2_data_d, frame_done_d;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [7:0]         head;
  logic               push, pop;

  assign in_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == S_IDLE) && (fifo_count != '0);
  assign busy     = (state != S_IDLE) || (fifo_count != '0);
  assign head     = mem[rd_ptr];

  // Byte storage; contents need no reset since count/pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Line values follow the current state and are registered, so both lines move together.
  always_comb begin
    state_d      = state;
    tmr_d        = tmr;
    bit_idx_d    = bit_idx;
    frame_d      = frame;
    ps2_clk_d    = 1'b1;
    ps2_data_d   = 1'b1;
    frame_done_d = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pop) begin
          frame_d   = {1'b1, ~^head, head, 1'b0};
          bit_idx_d = '0;
          tmr_d     = '0;
          state_d   = S_HIGH;
        end
      end
      S_HIGH: begin
        ps2_data_d = frame[bit_idx];
        if (tmr == TMR_W'(CLK_DIV - 1)) begin
          tmr_d   = '0;
          state_d = S_LOW;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end
      S_LOW: begin
        ps2_clk_d  = 1'b0;
        ps2_data_d = ps2_data;
        if (tmr == TMR_W'(CLK_DIV - 1)) begin
          tmr_d = '0;
          if (bit_idx == 4'(LAST_BIT)) begin
            state_d      = S_GAP;
            frame_done_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 4'd1;
            state_d   = S_HIGH;
          end
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end
      S_GAP: begin
        if (tmr == TMR_W'(GAP_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      tmr        <= '0;
      bit_idx    <= '0;
      frame      <= '0;
      ps2_clk    <= 1'b1;
      ps2_data   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      tmr        <= tmr_d;
      bit_idx    <= bit_idx_d;
      frame      <= frame_d;
      ps2_clk    <= ps2_clk_d;
      ps2_data   <= ps2_data_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: a driver pushes bytes and predicts each frame's start cycle; a
// monitor decodes the PS/2 lines like a host receiver and checks against the predictions.
module tb_ps2_device_tx;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned GAP_CYCLES = 8;
  localparam int FRAME_LEN = 22 * CLK_DIV;
  localparam int SPACING   = FRAME_LEN + GAP_CYCLES + 1;
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, ps2_clk, ps2_data, busy, frame_done;
  logic [CW-1:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: expected bytes, predicted start cycles and pop edges.
  logic [7:0] exp_byte[$];
  int         exp_start[$];
  int         pop_edge[$];
  int         n_popped = 0;
  int         last_start = -1000;

  // Receiver/monitor state.
  logic        prev_clk = 1'b1, prev_data = 1'b1;
  logic        in_frame = 1'b0;
  int          nbits = 0;
  logic [10:0] bits = '0;
  int          start_c = 0;
  int          fd_cnt = 0;
  int          frames_rx = 0;
  int          total_falls = 0;
  logic        saw_full = 1'b0;

  ps2_device_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy),
    .frame_done(frame_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a posedge; returns just after the edge that performed the push.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    int s;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("send_ready_timeout", int'(guard < 5000), 1);
    @(posedge clk); #1;
    s = (cyc + 2 > last_start + SPACING) ? cyc + 2 : last_start + SPACING;
    last_start = s;
    exp_byte.push_back(b);
    exp_start.push_back(s);
    pop_edge.push_back(s - 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    in_valid = 1'b0;
    while ((exp_byte.size() != 0 || in_frame || busy) && guard < 40000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk(name, int'(guard < 40000), 1);
    idle(5);
  endtask

  task automatic finish_frame();
    logic [7:0] eb;
    int es;
    eb = exp_byte.pop_front();
    es = exp_start.pop_front();
    chk("start_bit", int'(bits[0]), 0);
    chk("data_byte", int'(bits[8:1]), int'(eb));
    chk("parity_bit", int'(bits[9]), int'(($countones(eb) % 2) == 0));
    chk("stop_bit", int'(bits[10]), 1);
    chk("start_cycle", start_c, es);
    chk("frame_length", cyc - start_c, FRAME_LEN);
    chk("frame_done_pulses", fd_cnt, 1);
    frames_rx++;
    in_frame = 1'b0;
  endtask

  // Monitor: samples on the falling clk edge, away from the active edge.
  always @(negedge clk) begin
    int  mcnt;
    logic bexp;
    if (!resetn) begin
      in_frame = 1'b0;
      nbits = 0;
      exp_byte.delete();
      exp_start.delete();
      pop_edge.delete();
      n_popped = 0;
      last_start = -1000;
    end else begin
      while (n_popped < pop_edge.size() && pop_edge[n_popped] <= cyc) n_popped++;
      mcnt = pop_edge.size() - n_popped;
      bexp = (mcnt != 0) ||
             (n_popped > 0 && cyc <= pop_edge[n_popped-1] + FRAME_LEN + int'(GAP_CYCLES) - 1);
      chk("fifo_count", int'(fifo_count), mcnt);
      chk("in_ready", int'(in_ready), int'(mcnt < int'(FIFO_DEPTH)));
      chk("busy", int'(busy), int'(bexp));
      if (int'(fifo_count) == int'(FIFO_DEPTH)) saw_full = 1'b1;
      if (ps2_data != prev_data) chk("data_change_while_clk_low", int'(ps2_clk), 1);
      if (frame_done) begin
        chk("frame_done_in_frame", int'(in_frame), 1);
        fd_cnt++;
      end
      if (!in_frame && ps2_clk && prev_data && !ps2_data) begin
        chk("start_expected", int'(exp_byte.size() != 0), 1);
        if (exp_byte.size() != 0) begin
          in_frame = 1'b1;
          nbits = 0;
          start_c = cyc;
          fd_cnt = 0;
        end
      end
      if (prev_clk && !ps2_clk) begin
        total_falls++;
        if (!in_frame) chk("fall_outside_frame", int'(in_frame), 1);
        else if (nbits < 11) begin
          bits[nbits] = ps2_data;
          nbits++;
        end
      end
      if (!prev_clk && ps2_clk && in_frame && nbits == 11) finish_frame();
    end
    prev_clk = ps2_clk;
    prev_data = ps2_data;
  end

  initial begin
    int guard;
    int falls_snap;
    int rx_snap;
    logic [7:0] base;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ps2_clk", int'(ps2_clk), 1);
    chk("rst_ps2_data", int'(ps2_data), 1);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    resetn = 1'b1;
    idle(5);

    // Single frame 0x1C
    send(8'h1C);
    drain("drain_single");
    chk("frames_after_single", frames_rx, 1);

    // Parity corner bytes
    send(8'h00); idle(1);
    send(8'hFF); idle(1);
    send(8'h01);
    drain("drain_parity");

    // Back-to-back frames
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain("drain_b2b");

    // Hold valid with distinct bytes until the FIFO fills
    base = 8'($urandom);
    for (int i = 0; i < 20; i++) send(8'(base + 8'(i)));
    drain("drain_fill");
    chk("fifo_reached_full", int'(saw_full), 1);

    // Random bytes with random idle gaps
    for (int i = 0; i < 10; i++) begin
      send(8'($urandom));
      idle(int'($urandom_range(0, 150)));
    end
    drain("drain_random");

    // Reset during bit 5 with two bytes queued
    send(8'($urandom)); send(8'($urandom)); send(8'($urandom));
    in_valid = 1'b0;
    guard = 0;
    while (!(in_frame && nbits == 5 && ps2_clk) && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("reach_bit5", int'(guard < 2000), 1);
    chk("queued_before_reset", int'(fifo_count), 2);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("abort_ps2_clk", int'(ps2_clk), 1);
    chk("abort_ps2_data", int'(ps2_data), 1);
    chk("abort_fifo_count", int'(fifo_count), 0);
    chk("abort_busy", int'(busy), 0);
    falls_snap = total_falls;
    rx_snap = frames_rx;
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(400);
    chk("falls_after_abort", total_falls, falls_snap);
    chk("frames_after_abort", frames_rx, rx_snap);

    // Loopback of every byte value
    rx_snap = frames_rx;
    for (int i = 0; i < 256; i++) send(8'(i));
    drain("drain_all_bytes");
    chk("all_bytes_received", frames_rx - rx_snap, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
